// File: rtl/mux_scan_n_to_1_pkg.sv
// Shared definitions for the scanning N-to-1 multiplexer.
// Optional feature macro used by this block: MUX_SCAN_WRAP_PULSE_EN.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // $clog2 clamped to at least one bit so single-entry corners still elaborate
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan channel/dwell counter for mux_scan_n_to_1.
// With MUX_SCAN_WRAP_PULSE_EN defined, also produces the one-cycle scan_wrap pulse.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DWELL = 4,
    parameter int unsigned SW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan_on,
    input  logic          entry,
    input  logic [SW-1:0] start_idx,
    output logic [SW-1:0] idx_cur
`ifdef MUX_SCAN_WRAP_PULSE_EN
    ,
    output logic          scan_wrap
`endif
);

    localparam int unsigned DW = clog2_min1(DWELL);
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
    localparam logic [SW-1:0] ILAST = SW'(N_CH - 1);

    logic [SW-1:0] idx;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_cur;

    // The entry edge is itself the first dwell cycle: it uses the reloaded
    // index and a zero dwell count, then steps exactly like any other edge.
    always_comb begin
        idx_cur  = entry ? start_idx : idx;
        dcnt_cur = entry ? '0 : dcnt;
    end

    // Advance dwell count and channel index on enabled scan edges only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx  <= '0;
            dcnt <= '0;
        end else if (scan_on) begin
            if (dcnt_cur == DLAST) begin
                dcnt <= '0;
                idx  <= (idx_cur == ILAST) ? '0 : idx_cur + 1'b1;
            end else begin
                dcnt <= dcnt_cur + 1'b1;
                idx  <= idx_cur;
            end
        end
    end

`ifdef MUX_SCAN_WRAP_PULSE_EN
    // Pulse alongside the first output cycle of channel 0 reached by wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_wrap <= 1'b0;
        end else begin
            scan_wrap <= scan_on && !entry && (idx == '0) && (dcnt == '0);
        end
    end
`endif

endmodule

// File: rtl/mux_scan_n_to_1.sv
// Registered N-to-1 multiplexer with manual select and timed channel scan.
// Optional feature macro: MUX_SCAN_WRAP_PULSE_EN (adds scan_wrap output).
module mux_scan_n_to_1
    import mux_pkg::*;
#(
    parameter  int unsigned N_CH  = 8,
    parameter  int unsigned W     = 8,
    parameter  int unsigned DWELL = 4,
    localparam int unsigned SW    = clog2_min1(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH*W-1:0] X,
    input  logic [SW-1:0]   S,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    Y,
    output logic            Y_valid,
    output logic [SW-1:0]   ch_out
`ifdef MUX_SCAN_WRAP_PULSE_EN
    ,
    output logic            scan_wrap
`endif
);

    localparam logic [SW:0] NCH_L = (SW + 1)'(N_CH);

    mode_e         mode_q;
    mode_e         mode_d;
    logic          scan_on;
    logic          entry;
    logic [SW-1:0] start_idx;
    logic [SW-1:0] scan_idx;
    logic [SW-1:0] sel;
    logic          sel_legal;
    logic [W-1:0]  ch_data [2**SW];

    // Mode state register; en=0 holds it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_MANUAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode follows the mode input on enabled edges
    always_comb begin
        mode_d = mode_q;
        if (en) begin
            mode_d = mode ? MODE_SCAN : MODE_MANUAL;
        end
    end

    // Scan control and channel selection for the current edge
    always_comb begin
        scan_on   = en && mode;
        entry     = scan_on && (mode_q == MODE_MANUAL);
        start_idx = ({1'b0, S} < NCH_L) ? S : '0;
        sel       = scan_on ? scan_idx : S;
        sel_legal = ({1'b0, sel} < NCH_L);
    end

    // Unpack channels; slots past N_CH read as zero
    always_comb begin
        for (int unsigned k = 0; k < 2**SW; k++) begin
            ch_data[k] = '0;
        end
        for (int unsigned k = 0; k < N_CH; k++) begin
            ch_data[k] = X[k*W +: W];
        end
    end

    mux_scan_ctr #(
        .N_CH  (N_CH),
        .DWELL (DWELL),
        .SW    (SW)
    ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_on   (scan_on),
        .entry     (entry),
        .start_idx (start_idx),
        .idx_cur   (scan_idx)
`ifdef MUX_SCAN_WRAP_PULSE_EN
        ,
        .scan_wrap (scan_wrap)
`endif
    );

    // Registered output slice; illegal selects yield zero and no valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y       <= '0;
            Y_valid <= 1'b0;
            ch_out  <= '0;
        end else if (en) begin
            Y       <= sel_legal ? ch_data[sel] : '0;
            Y_valid <= sel_legal;
            ch_out  <= sel;
        end else begin
            Y_valid <= 1'b0;
        end
    end

endmodule
